sprite_walk_sequencer: RTL
==========================

Name: sprite_walk_sequencer

Overview:
Sequences the player character's walk cycle. It accepts movement requests from the input/game logic and advances pose and pixel offset once per video frame (vsync-derived tick). It drives the sprite-sheet base column and the scroll offset that the colour mapper and map renderer consume. It replaces free-running per-clock animation with frame-paced, tile-quantised motion.

Parameters:
TILE_PX, 16, pixels per tile step; frame ticks per walk step (2..32)
FRAMES_PER_POSE, 4, frame ticks per pose advance while walking
TURN_FRAMES, 2, frame ticks the sequencer stays busy after a turn-in-place
SPR_W, 19, sprite width in sheet pixels; base column = (facing*4 + pose)*SPR_W

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous active-high reset
frame_tick  in  1  one-Clk pulse per frame (vsync edge), synchronous to Clk
move_req  in  1  level: player requests movement
move_dir  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
move_ack  out  1  one-cycle pulse: request accepted
busy  out  1  high in TURN or WALK
facing  out  2  current facing direction, same encoding as move_dir
pose  out  2  0 Rest1, 1 Move1, 2 Rest2, 3 Move2
pixel_offset  out  5  pixels travelled within current tile, 0..TILE_PX-1
step_done  out  1  one-cycle pulse: one tile of movement completed
sprite_base  out  14  sheet column of the current frame, (facing*4+pose)*SPR_W

Behaviour:
- Reset (async, any state): state IDLE, facing=2, pose=0, pixel_offset=0, move_ack=0, step_done=0, busy=0, sprite_base=152, all counters 0.
- All outputs are registered. sprite_base is combinational from registered facing/pose (no added latency).
- States: IDLE, TURN, WALK.
- IDLE: a request is accepted on any cycle with move_req=1; move_ack pulses on the next cycle.
  - move_dir != facing -> TURN; facing<=move_dir, pose<=0, turn_cnt<=0.
  - move_dir == facing -> WALK; pose<=1, pose_cnt<=0, tick_cnt<=0, pixel_offset<=0.
  - A frame_tick in the acceptance cycle is not counted; counting starts on the next tick.
- TURN: each frame_tick increments turn_cnt. On the TURN_FRAMES-th tick -> IDLE. move_req is ignored. step_done is never raised and pixel_offset stays 0.
- WALK: each frame_tick does the following.
  - pixel_offset increments.
  - pose_cnt increments. When it reaches FRAMES_PER_POSE, pose_cnt<=0 and pose advances 1->2->3->0->1 (wrap).
  - On the TILE_PX-th tick of the step: pixel_offset<=0, and step_done pulses in the following cycle (concurrent with the registered update).
  - If move_req=1 and move_dir==facing in that tick cycle: stay in WALK, tick_cnt<=0. Pose sequence and pose_cnt continue unbroken, with no idle gap. move_ack pulses again for the chained step.
  - Otherwise -> IDLE with pose<=0. A differing direction is then handled from IDLE, the first cycle after it has been entered.
- move_req/move_dir outside the two acceptance points above (IDLE; last WALK tick) are ignored; no queuing.
- frame_tick in IDLE has no effect.
- Reset mid-WALK/TURN returns immediately to the reset values. No step_done is emitted for the partial step.
- Arithmetic: counters are unsigned; pixel_offset never reaches TILE_PX. sprite_base maximum (15*19=285) fits 14 bits.

Test Plan:
- Reset then idle 100 cycles with ticks -> facing=2, pose=0, sprite_base=152, busy=0, pixel_offset=0, no step_done.
- move_req=1, dir=2 for one cycle, then 16 ticks -> ack once.
  - pixel_offset runs 1..15 then 0.
  - pose reads 1 after ticks 0-3, 2 after ticks 4-7, 3 after ticks 8-11, 0 after tick 12. It wraps to 1 at tick 16, then is forced to 0 on return to IDLE.
  - step_done pulses once after tick 16; returns to IDLE with sprite_base=152.
- From facing 2, move_req dir=1 -> facing=1 and sprite_base=76 on the next cycle; busy for exactly 2 ticks; pixel_offset=0; no step_done.
- Hold move_req dir=2 for 40 ticks -> step_done after ticks 16 and 32; busy never drops; pose continues cycling with no reset at the boundary.
- Assert Reset asynchronously mid-walk after tick 7 -> all outputs at reset values without a Clk edge; no step_done.
- move_req dir=0 during WALK -> no ack and no facing change. frame_tick coincident with acceptance -> pixel_offset is 1 only after the next tick.

Source files
------------

// File: rtl/sprite_walk_sequencer.sv
// Frame-paced walk-cycle sequencer for the player sprite.
// Accepts movement requests, turns in place or walks one tile per step,
// advancing pose and pixel offset only on frame ticks. Drives the
// sprite-sheet base column and the in-tile scroll offset.
module sprite_walk_sequencer #(
  parameter int TILE_PX         = 16,
  parameter int FRAMES_PER_POSE = 4,
  parameter int TURN_FRAMES     = 2,
  parameter int SPR_W           = 19
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        move_req,
  input  logic [1:0]  move_dir,
  output logic        move_ack,
  output logic        busy,
  output logic [1:0]  facing,
  output logic [1:0]  pose,
  output logic [4:0]  pixel_offset,
  output logic        step_done,
  output logic [13:0] sprite_base
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_WALK = 2'd2
  } state_t;

  // Terminal counts, sized to the counter registers they are compared with.
  localparam logic [4:0]  TICK_LAST = 5'(TILE_PX - 1);
  localparam logic [4:0]  POSE_LAST = 5'(FRAMES_PER_POSE - 1);
  localparam logic [4:0]  TURN_LAST = 5'(TURN_FRAMES - 1);
  localparam logic [13:0] SPR_W_L   = 14'(SPR_W);

  // Reset-time facing is "down" (2); its sheet column follows from SPR_W.
  localparam logic [1:0]  FACE_RST  = 2'd2;

  state_t     state_q;
  logic       busy_q;
  logic       move_ack_q;
  logic       step_done_q;
  logic [1:0] facing_q;
  logic [1:0] pose_q;
  logic [4:0] tick_cnt_q;
  logic [4:0] pose_cnt_q;
  logic [4:0] turn_cnt_q;

  logic [4:0] pose_cnt_d;
  logic [1:0] pose_d;
  logic       step_last;
  logic       turn_last;
  logic       chain_ok;

  // Pose order Rest1 -> Move1 -> Rest2 -> Move2 -> Rest1 is a plain 2-bit wrap.
  function automatic logic [1:0] pose_advance(input logic [1:0] p);
    return p + 2'd1;
  endfunction

  // Per-tick helper values: pose cadence, end of step, end of turn, chaining.
  always_comb begin
    pose_cnt_d = pose_cnt_q + 5'd1;
    pose_d     = pose_q;
    if (pose_cnt_q == POSE_LAST) begin
      pose_cnt_d = '0;
      pose_d     = pose_advance(pose_q);
    end
    step_last = (tick_cnt_q == TICK_LAST);
    turn_last = (turn_cnt_q == TURN_LAST);
    chain_ok  = move_req && (move_dir == facing_q);
  end

  // Walk/turn sequencer; every output is produced from a register here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      move_ack_q  <= 1'b0;
      step_done_q <= 1'b0;
      facing_q    <= FACE_RST;
      pose_q      <= 2'd0;
      tick_cnt_q  <= '0;
      pose_cnt_q  <= '0;
      turn_cnt_q  <= '0;
    end else begin
      move_ack_q  <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Any frame_tick here is deliberately ignored, including one in the
          // acceptance cycle: counting starts on the first tick after it.
          if (move_req) begin
            move_ack_q <= 1'b1;
            busy_q     <= 1'b1;
            if (move_dir != facing_q) begin
              state_q    <= ST_TURN;
              facing_q   <= move_dir;
              pose_q     <= 2'd0;
              turn_cnt_q <= '0;
            end else begin
              state_q    <= ST_WALK;
              pose_q     <= 2'd1;
              pose_cnt_q <= '0;
              tick_cnt_q <= '0;
            end
          end
        end

        ST_TURN: begin
          // Requests are not looked at while turning; only ticks matter.
          if (frame_tick) begin
            if (turn_last) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              turn_cnt_q <= '0;
            end else begin
              turn_cnt_q <= turn_cnt_q + 5'd1;
            end
          end
        end

        ST_WALK: begin
          if (frame_tick) begin
            pose_cnt_q <= pose_cnt_d;
            if (step_last) begin
              // Tile boundary: offset wraps and the step is reported.
              tick_cnt_q  <= '0;
              step_done_q <= 1'b1;
              if (chain_ok) begin
                // Same direction still held: continue with no idle gap and
                // an unbroken pose cadence.
                move_ack_q <= 1'b1;
                pose_q     <= pose_d;
              end else begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                pose_q     <= 2'd0;
                pose_cnt_q <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 5'd1;
              pose_q     <= pose_d;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign move_ack     = move_ack_q;
  assign busy         = busy_q;
  assign facing       = facing_q;
  assign pose         = pose_q;
  assign pixel_offset = tick_cnt_q;
  assign step_done    = step_done_q;
  // Sheet column: four poses per facing row, SPR_W pixels per pose.
  assign sprite_base  = {10'd0, facing_q, pose_q} * SPR_W_L;

endmodule
